// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xor2_sched.sv
// Two-requester scheduler time-sharing one bit-serial XOR2 to compute word parity.
// Define GF180MCU_FD_SC_MCU9T5V0__XOR2_SCHED_FIXPRI_EN for fixed priority (REQ1 wins); default is round-robin.
module gf180mcu_fd_sc_mcu9t5v0__xor2_sched #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             REQ1,
   input  logic [WIDTH-1:0] D1,
   input  logic             REQ2,
   input  logic [WIDTH-1:0] D2,
   output logic             ACK1,
   output logic             ACK2,
   output logic             BUSY,
   output logic             Z,
   output logic             ZV,
   output logic             ZID
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sr;
   logic             r_acc;
   logic [CW-1:0]    r_cnt;
   logic             r_last;
   logic             r_ack1;
   logic             r_ack2;
   logic             r_z;
   logic             r_zv;
   logic             r_zid;
   logic             w_grant;
   logic             w_winner;
   logic             w_cnt_zero;

   assign w_cnt_zero = (r_cnt == '0);

   // NOTE: all sequential state uses non-blocking assignments; RN only acts on a clock edge.
   always_ff @(posedge CLK) begin
      if (!RN) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_cnt_zero) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      // NOTE: defaults first so this block cannot infer a latch.
      w_grant  = 1'b0;
      w_winner = 1'b0;
      BUSY     = (r_state != S_IDLE);
      if (r_state == S_IDLE && (REQ1 || REQ2)) begin
         w_grant = 1'b1;
         if (REQ1 && REQ2) begin
`ifdef GF180MCU_FD_SC_MCU9T5V0__XOR2_SCHED_FIXPRI_EN
            w_winner = r_last & 1'b0;  // LAST kept current but ignored
`else
            w_winner = ~r_last;
`endif
         end else begin
            w_winner = REQ2;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RN) begin
         r_sr   <= '0;
         r_acc  <= 1'b0;
         r_cnt  <= '0;
         r_last <= 1'b1;
         r_ack1 <= 1'b0;
         r_ack2 <= 1'b0;
         r_z    <= 1'b0;
         r_zv   <= 1'b0;
         r_zid  <= 1'b0;
      end else begin
         r_ack1 <= 1'b0;
         r_ack2 <= 1'b0;
         r_zv   <= 1'b0;
         if (w_grant) begin
            r_sr   <= w_winner ? D2 : D1;
            r_acc  <= 1'b0;
            r_cnt  <= CW'(WIDTH - 1);
            r_ack1 <= ~w_winner;
            r_ack2 <= w_winner;
            r_zid  <= w_winner;
            r_last <= w_winner;
         end else if (r_state == S_SHIFT) begin
            r_acc <= r_acc ^ r_sr[0];
            r_sr  <= r_sr >> 1;
            r_cnt <= r_cnt - 1'b1;
            if (w_cnt_zero) begin
               r_z  <= r_acc ^ r_sr[0];
               r_zv <= 1'b1;
            end
         end
      end
   end

   assign ACK1 = r_ack1;
   assign ACK2 = r_ack2;
   assign Z    = r_z;
   assign ZV   = r_zv;
   assign ZID  = r_zid;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__xor2_sched.sv
// Bench for the XOR2 parity scheduler: directed job table, contention/reset sequences,
// plus a transaction-level reference model checked every cycle under random traffic.
module tb_gf180mcu_fd_sc_mcu9t5v0__xor2_sched;
   localparam int WIDTH = 8;

   logic             CLK = 1'b0;
   logic             RN;
   logic             REQ1;
   logic             REQ2;
   logic [WIDTH-1:0] D1;
   logic [WIDTH-1:0] D2;
   logic             ACK1;
   logic             ACK2;
   logic             BUSY;
   logic             Z;
   logic             ZV;
   logic             ZID;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit         id;
      logic [7:0] d;
      logic [7:0] d_after;
      bit         exp_z;
   } job_t;

   job_t jobs[8];

   always #5 CLK = ~CLK;

   gf180mcu_fd_sc_mcu9t5v0__xor2_sched #(.WIDTH(WIDTH)) dut (
      .CLK (CLK),
      .RN  (RN),
      .REQ1(REQ1),
      .D1  (D1),
      .REQ2(REQ2),
      .D2  (D2),
      .ACK1(ACK1),
      .ACK2(ACK2),
      .BUSY(BUSY),
      .Z   (Z),
      .ZV  (ZV),
      .ZID (ZID)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_zv(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (ZV !== 1'b1 && n < 40);
      check("zv_seen", ZV, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (BUSY !== 1'b0 && n < 40) begin
         step();
         n++;
      end
      check("idle_seen", BUSY, 0);
   endtask

   // Transaction-level reference: a job is an age counter plus the word's parity.
   bit m_started = 1'b0;
   int m_age = -1;
   bit m_last = 1'b1;
   bit m_par, m_win;
   bit e_ack1, e_ack2, e_z, e_zv, e_zid;

   always @(posedge CLK) begin
      m_started = 1'b1;
      if (!RN) begin
         m_age = -1; m_last = 1'b1;
         e_ack1 = 0; e_ack2 = 0; e_z = 0; e_zv = 0; e_zid = 0;
      end else begin
         e_ack1 = 0; e_ack2 = 0; e_zv = 0;
         if (m_age < 0) begin
            if (REQ1 || REQ2) begin
               if (REQ1 && REQ2) begin
`ifdef GF180MCU_FD_SC_MCU9T5V0__XOR2_SCHED_FIXPRI_EN
                  m_win = 1'b0;
`else
                  m_win = !m_last;
`endif
               end else begin
                  m_win = REQ2;
               end
               m_par  = m_win ? ^D2 : ^D1;
               e_ack1 = !m_win;
               e_ack2 = m_win;
               e_zid  = m_win;
               m_last = m_win;
               m_age  = 0;
            end
         end else begin
            m_age++;
            if (m_age == WIDTH) begin
               e_z  = m_par;
               e_zv = 1'b1;
            end else if (m_age == WIDTH + 1) begin
               m_age = -1;
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (m_started)
         check("cycle", {ACK1, ACK2, BUSY, Z, ZV, ZID},
               {e_ack1, e_ack2, (m_age >= 0), e_z, e_zv, e_zid});
   end

   task automatic run_job(input job_t j, input int k);
      int n = 0;
      if (j.id) begin REQ2 = 1'b1; D2 = j.d; end
      else      begin REQ1 = 1'b1; D1 = j.d; end
      do begin
         step();
         n++;
      end while (!(ACK1 || ACK2) && n < 20);
      check($sformatf("job%0d_ack", k), {ACK1, ACK2, BUSY}, j.id ? 3'b011 : 3'b101);
      if (j.id) begin REQ2 = 1'b0; D2 = j.d_after; end
      else      begin REQ1 = 1'b0; D1 = j.d_after; end
      wait_zv(n);
      check($sformatf("job%0d_latency", k), n, WIDTH);
      check($sformatf("job%0d_z", k), Z, j.exp_z);
      check($sformatf("job%0d_zid", k), ZID, j.id);
      step();
      step();
      check($sformatf("job%0d_busy_low", k), BUSY, 0);
   endtask

   initial begin
      int n;
      logic [2:0] exp_cz;
      logic [2:0] exp_cid;
`ifdef GF180MCU_FD_SC_MCU9T5V0__XOR2_SCHED_FIXPRI_EN
      exp_cz  = 3'b000;
      exp_cid = 3'b000;
`else
      exp_cz  = 3'b010;
      exp_cid = 3'b010;
`endif
      jobs[0] = '{1'b0, 8'hA5, 8'hA5, 1'b0};
      jobs[1] = '{1'b1, 8'h07, 8'h07, 1'b1};
      jobs[2] = '{1'b0, 8'hFF, 8'h01, 1'b0};
      jobs[3] = '{1'b1, 8'h80, 8'h00, 1'b1};
      jobs[4] = '{1'b0, 8'h00, 8'hFF, 1'b0};
      jobs[5] = '{1'b1, 8'h3C, 8'h3C, 1'b0};
      jobs[6] = '{1'b0, 8'h7F, 8'h7F, 1'b1};
      jobs[7] = '{1'b1, 8'hFE, 8'h01, 1'b1};

      // Reset with both requesters active, then contention.
      RN = 1'b0; REQ1 = 1'b1; REQ2 = 1'b1; D1 = 8'hA5; D2 = 8'h07;
      step();
      step();
      check("reset_outputs", {ACK1, ACK2, BUSY, Z, ZV, ZID}, 6'b0);
      RN = 1'b1;
      step();
      check("first_grant_req1", {ACK1, ACK2, BUSY}, 3'b101);
      for (int k = 0; k < 3; k++) begin
         wait_zv(n);
         check($sformatf("cont%0d_spacing", k), n, (k == 0) ? WIDTH : WIDTH + 2);
         check($sformatf("cont%0d_z", k), Z, exp_cz[k]);
         check($sformatf("cont%0d_zid", k), ZID, exp_cid[k]);
      end
      REQ1 = 1'b0;
      wait_zv(n);
      check("after_drop_spacing", n, WIDTH + 2);
      check("after_drop_z", Z, 1);
      check("after_drop_zid", ZID, 1);
      REQ2 = 1'b0;
      wait_idle();

      foreach (jobs[k]) run_job(jobs[k], k);
      wait_idle();

      // Reset at the 4th shift edge aborts the job; pending REQ2 then gets a fresh grant.
      REQ1 = 1'b1; D1 = 8'h55;
      n = 0;
      do begin step(); n++; end while (!ACK1 && n < 20);
      check("abort_ack1", ACK1, 1);
      REQ1 = 1'b0; REQ2 = 1'b1; D2 = 8'h80;
      step();
      step();
      step();
      RN = 1'b0;
      step();
      check("abort_reset_outputs", {ACK1, ACK2, BUSY, Z, ZV, ZID}, 6'b0);
      RN = 1'b1;
      step();
      check("abort_regrant_ack2", {ACK1, ACK2, BUSY}, 3'b011);
      REQ2 = 1'b0;
      wait_zv(n);
      check("abort_regrant_latency", n, WIDTH);
      check("abort_regrant_z", Z, 1);
      check("abort_regrant_zid", ZID, 1);
      wait_idle();

      // Random traffic against the reference model, with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         RN = ($urandom_range(0, 99) != 0);
         step();
         if (ACK1) REQ1 = 1'b0;
         if (!REQ1) begin
            D1 = 8'($urandom);
            if ($urandom_range(0, 2) == 0) REQ1 = 1'b1;
         end
         if (ACK2) REQ2 = 1'b0;
         if (!REQ2) begin
            D2 = 8'($urandom);
            if ($urandom_range(0, 2) == 0) REQ2 = 1'b1;
         end
      end
      RN = 1'b1; REQ1 = 1'b0; REQ2 = 1'b0;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
